// File: rtl/mips_alu_muldiv_seq.sv
// Multicycle multiply/divide sequencer that owns the MIPS HI/LO registers.
// Ports: clk/reset (sync, active-high); issue/func/data1/data2 from execute;
//        stall (comb), busy (registered state), reg_lo/reg_hi (registered HI/LO).
// Latency: mult/div occupy DATA_W RUN cycles plus one FIX cycle; mt*/mf* complete at accept.
// Backpressure: HI/LO-class ops stall while busy; all other ops pass through untouched.
module mips_alu_muldiv_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1,
    parameter int FUNC_W = 4,
    parameter logic [FUNC_W-1:0] F_MULS = 4'h8,
    parameter logic [FUNC_W-1:0] F_MULU = 4'h9,
    parameter logic [FUNC_W-1:0] F_DIVS = 4'hA,
    parameter logic [FUNC_W-1:0] F_DIVU = 4'hB,
    parameter logic [FUNC_W-1:0] F_MTLO = 4'hC,
    parameter logic [FUNC_W-1:0] F_MTHI = 4'hD,
    parameter logic [FUNC_W-1:0] F_MFLO = 4'hE,
    parameter logic [FUNC_W-1:0] F_MFHI = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [FUNC_W-1:0] func,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] reg_lo,
    output logic [DATA_W-1:0] reg_hi
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt;
    // p_hi/p_lo: product accumulator for multiply, remainder/quotient for divide
    logic [DATA_W-1:0] p_hi, p_lo;
    logic [DATA_W-1:0] op_b;       // multiplicand or divisor magnitude
    logic              is_div;
    logic              div0;
    logic              neg_q;      // negate product / quotient
    logic              neg_r;      // negate remainder (dividend sign)

    logic              hilo_op, accept, start, is_signed;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W+1:0] div_diff;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    assign busy = (state_q != IDLE);

    always_comb begin
        hilo_op   = (func == F_MULS) || (func == F_MULU) || (func == F_DIVS) ||
                    (func == F_DIVU) || (func == F_MTLO) || (func == F_MTHI) ||
                    (func == F_MFLO) || (func == F_MFHI);
        stall     = issue & busy & hilo_op;
        accept    = issue & ~busy & hilo_op;
        start     = accept & ((func == F_MULS) || (func == F_MULU) ||
                              (func == F_DIVS) || (func == F_DIVU));
        is_signed = (func == F_MULS) || (func == F_DIVS);
        // Two's-complement magnitude; the most negative value maps to itself as unsigned.
        mag_a = (is_signed && data1[DATA_W-1]) ? (~data1 + 1'b1) : data1;
        mag_b = (is_signed && data2[DATA_W-1]) ? (~data2 + 1'b1) : data2;

        // Shift-add step: conditionally add multiplicand into the upper half, then shift right.
        mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, op_b} : '0);
        // Restoring step: shift next dividend bit into remainder and trial-subtract.
        div_shift = {p_hi, p_lo[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, op_b};

        prod_fix = neg_q ? (~{p_hi, p_lo} + 1'b1) : {p_hi, p_lo};
        quo_fix  = neg_q ? (~p_lo + 1'b1) : p_lo;
        rem_fix  = neg_r ? (~p_hi + 1'b1) : p_hi;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            op_b   <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            reg_lo <= '0;
            reg_hi <= '0;
        end else begin
            if (accept && func == F_MTLO) reg_lo <= data1;
            if (accept && func == F_MTHI) reg_hi <= data1;

            if (start) begin
                cnt    <= CNT_W'(DATA_W);
                is_div <= (func == F_DIVS) || (func == F_DIVU);
                div0   <= ((func == F_DIVS) || (func == F_DIVU)) && (data2 == '0);
                neg_q  <= is_signed && (data1[DATA_W-1] ^ data2[DATA_W-1]);
                neg_r  <= is_signed && data1[DATA_W-1];
                p_hi   <= '0;
                if ((func == F_DIVS) || (func == F_DIVU)) begin
                    p_lo <= mag_a;
                    op_b <= mag_b;
                end else begin
                    p_lo <= mag_b;
                    op_b <= mag_a;
                end
            end

            if (state_q == RUN) begin
                cnt <= cnt - 1'b1;
                if (is_div) begin
                    if (!div_diff[DATA_W+1]) begin
                        p_hi <= div_diff[DATA_W-1:0];
                        p_lo <= {p_lo[DATA_W-2:0], 1'b1};
                    end else begin
                        p_hi <= div_shift[DATA_W-1:0];
                        p_lo <= {p_lo[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    p_hi <= mul_sum[DATA_W:1];
                    p_lo <= {mul_sum[0], p_lo[DATA_W-1:1]};
                end
            end

            if (state_q == FIX) begin
                if (!is_div) begin
                    {reg_hi, reg_lo} <= prod_fix;
                end else if (div0) begin
                    // With a zero divisor every trial subtract succeeds, so the remainder
                    // register ends holding |dividend|; re-applying the dividend sign
                    // restores the raw dividend.
                    reg_lo <= '1;
                    reg_hi <= rem_fix;
                end else begin
                    reg_lo <= quo_fix;
                    reg_hi <= rem_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_alu_muldiv_seq.sv
module tb_mips_alu_muldiv_seq;

    localparam logic [3:0] F_ADD  = 4'h0;
    localparam logic [3:0] F_MULS = 4'h8;
    localparam logic [3:0] F_MULU = 4'h9;
    localparam logic [3:0] F_DIVS = 4'hA;
    localparam logic [3:0] F_DIVU = 4'hB;
    localparam logic [3:0] F_MTLO = 4'hC;
    localparam logic [3:0] F_MTHI = 4'hD;
    localparam logic [3:0] F_MFLO = 4'hE;
    localparam logic [3:0] F_MFHI = 4'hF;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue;
    logic [3:0]  func;
    logic [31:0] data1, data2;
    logic        stall, busy;
    logic [31:0] reg_lo, reg_hi;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] mhi = 32'h0;
    logic [31:0] mlo = 32'h0;

    mips_alu_muldiv_seq dut (
        .clk(clk), .reset(reset), .issue(issue), .func(func),
        .data1(data1), .data2(data2), .stall(stall), .busy(busy),
        .reg_lo(reg_lo), .reg_hi(reg_hi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_hilo(input logic [3:0] f);
        return f >= 4'h8;
    endfunction

    function automatic logic is_muldiv(input logic [3:0] f);
        return f inside {F_MULS, F_MULU, F_DIVS, F_DIVU};
    endfunction

    // Reference: architectural HI/LO semantics from plain 64-bit arithmetic.
    task automatic model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            F_MULS: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
            F_MULU: begin p = {32'h0, a} * {32'h0, b}; mhi = p[63:32]; mlo = p[31:0]; end
            F_DIVS, F_DIVU: begin
                if (b == 0) begin
                    mlo = 32'hFFFF_FFFF; mhi = a;
                end else if (f == F_DIVS) begin
                    q = sa / sb; r = sa % sb;
                    mlo = 32'(q); mhi = 32'(r);
                end else begin
                    mlo = a / b; mhi = a % b;
                end
            end
            F_MTLO: mlo = a;
            F_MTHI: mhi = a;
            default: ;
        endcase
    endtask

    // Called just after a rising edge with the unit idle. Issues one op, then for
    // mult/div checks exact busy length, HI/LO hold during RUN, and stall behaviour
    // of interleaved issues.
    task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic noise);
        int n;
        int pick;
        logic [31:0] lo0, hi0;
        issue = 1'b1; func = f; data1 = a; data2 = b;
        #2;
        chk("stall_idle", {63'h0, stall}, 64'h0);
        if (f == F_MFLO) chk("mflo_val", {32'h0, reg_lo}, {32'h0, mlo});
        if (f == F_MFHI) chk("mfhi_val", {32'h0, reg_hi}, {32'h0, mhi});
        @(posedge clk); #1;
        issue = 1'b0; func = F_ADD;
        lo0 = mlo; hi0 = mhi;
        model(f, a, b);
        if (is_muldiv(f)) begin
            n = 0;
            while (busy && n < 100) begin
                chk("hold_hilo", {reg_hi, reg_lo}, {hi0, lo0});
                if (noise) begin
                    pick  = $urandom_range(0, 3);
                    issue = (pick != 0);
                    func  = (pick == 1) ? F_ADD : (pick == 2) ? F_MFLO : F_MFHI;
                    data1 = $urandom;
                    #2;
                    chk("stall_busy", {63'h0, stall}, {63'h0, (issue && is_hilo(func))});
                end
                @(posedge clk); #1;
                n++;
            end
            issue = 1'b0; func = F_ADD;
            chk("busy_len", 64'(n), 64'd33);
        end
        chk("res_lo", {32'h0, reg_lo}, {32'h0, mlo});
        chk("res_hi", {32'h0, reg_hi}, {32'h0, mhi});
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        logic [3:0]  f;
        reset = 1'b1; issue = 1'b0; func = F_ADD; data1 = '0; data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        // Issue a mult while reset is held: reset wins, nothing starts.
        issue = 1'b1; func = F_MULU; data1 = 32'd5; data2 = 32'd7;
        #2;
        chk("rst_stall", {63'h0, stall}, 64'h0);
        @(posedge clk); #1;
        issue = 1'b0;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_lo", {32'h0, reg_lo}, 64'h0);
        chk("rst_hi", {32'h0, reg_hi}, 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_nostart", {63'h0, busy}, 64'h0);

        // Directed vectors
        do_op(F_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(F_MULS, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op(F_MULS, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(F_DIVS, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(F_DIVU, 32'd7, 32'd2, 1'b0);
        do_op(F_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(F_DIVU, 32'd10, 32'd0, 1'b0);
        do_op(F_DIVS, 32'hFFFF_FFFB, 32'd0, 1'b0);

        // mult followed by a held mflo: stalls for the whole occupancy, then reads new LO
        issue = 1'b1; func = F_MULU; data1 = 32'h0001_2345; data2 = 32'h0006_789A;
        @(posedge clk); #1;
        model(F_MULU, 32'h0001_2345, 32'h0006_789A);
        func = F_MFLO;
        n = 0;
        #1;
        while (stall && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("mflo_stall_len", 64'(n), 64'd33);
        chk("mflo_new_lo", {32'h0, reg_lo}, {32'h0, mlo});
        @(posedge clk); #1;
        issue = 1'b0; func = F_ADD;

        // mult with an add issued on every busy cycle: add never stalls
        issue = 1'b1; func = F_MULS; data1 = 32'hFFFF_0001; data2 = 32'h0000_7FFF;
        @(posedge clk); #1;
        model(F_MULS, 32'hFFFF_0001, 32'h0000_7FFF);
        func = F_ADD;
        n = 0;
        while (busy && n < 100) begin
            #1;
            chk("add_nostall", {63'h0, stall}, 64'h0);
            @(posedge clk); #1;
            n++;
        end
        issue = 1'b0;
        chk("add_busy_len", 64'(n), 64'd33);
        chk("add_res_lo", {32'h0, reg_lo}, {32'h0, mlo});

        // mtlo then mthi on consecutive cycles
        issue = 1'b1; func = F_MTLO; data1 = 32'h1234_5678;
        #1; chk("mtlo_stall", {63'h0, stall}, 64'h0);
        @(posedge clk); #1;
        chk("mtlo_lo", {32'h0, reg_lo}, 64'h1234_5678);
        func = F_MTHI; data1 = 32'hCAFE_F00D;
        #1; chk("mthi_stall", {63'h0, stall}, 64'h0);
        @(posedge clk); #1;
        chk("mthi_hi", {32'h0, reg_hi}, 64'hCAFE_F00D);
        issue = 1'b0; func = F_ADD;
        model(F_MTLO, 32'h1234_5678, 0);
        model(F_MTHI, 32'hCAFE_F00D, 0);

        // reset part-way through a divide discards it
        do_op(F_MTHI, 32'h1111, 0, 1'b0);
        do_op(F_MTLO, 32'h2222, 0, 1'b0);
        issue = 1'b1; func = F_DIVU; data1 = 32'd1000; data2 = 32'd7;
        @(posedge clk); #1;
        issue = 1'b0; func = F_ADD;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_busy", {63'h0, busy}, 64'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mhi = '0; mlo = '0;
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_hilo", {reg_hi, reg_lo}, 64'h0);
        do_op(F_MULU, 32'd2, 32'd3, 1'b0);

        // Randomized mix, including corner operands
        for (int i = 0; i < 120; i++) begin
            f = 4'(8 + $urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(f, a, b, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
